// File: rtl/block_ram_resp_fifo.sv
// Circular response FIFO used by block_ram_client. Storage is deliberately
// not reset; occupancy and pointers are. The parent guarantees that it never
// enqueues into a full FIFO or dequeues from an empty one.
module block_ram_resp_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 3,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enq_i,
  input  logic [DATA_WIDTH-1:0] enq_data_i,
  input  logic                  deq_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CW-1:0]         count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy next-state; simultaneous enq/deq leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(enq_i) - CW'(deq_i);
    if (enq_i) wr_ptr_d = bump(wr_ptr_q);
    if (deq_i) rd_ptr_d = bump(rd_ptr_q);
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage, written at the write pointer; no reset needed.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/block_ram_client.sv
// Requester-side front end for a single-port block RAM with 1-cycle read
// latency and unheld data out. Every accepted read reserves a FIFO slot up
// front (credit), so RAM_DO can be captured unconditionally the cycle after
// the read issues and consumer backpressure never drops data.
module block_ram_client #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic                  RAM_WE,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic          fire;
  logic          deq;
  logic          inflight_q, inflight_d;
  logic          ready_en_q;
  logic [CW-1:0] count;
  logic [CW:0]   used;

  assign fire = REQ_VALID & REQ_READY;
  assign deq  = RESP_VALID & RESP_READY;

  assign RAM_ADDR = REQ_ADDR;
  assign RAM_DI   = REQ_DATA;
  assign RAM_WE   = fire & REQ_WE;

  assign inflight_d = fire & ~REQ_WE;

  // Slots already promised: queued responses plus the read now on RAM_DO.
  // Registers only, so no path from RESP_READY/REQ_VALID to REQ_READY.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign REQ_READY = ready_en_q & (used < (CW+1)'(RESP_DEPTH));

  assign RESP_VALID = (count != '0);

  // Read-issue tracking and the post-reset ready enable (keeps READY low in reset).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inflight_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ready_en_q <= 1'b1;
    end
  end

  block_ram_resp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .enq_i     (inflight_q),
    .enq_data_i(RAM_DO),
    .deq_i     (deq),
    .data_o    (RESP_DATA),
    .count_o   (count)
  );

endmodule

// File: tb/tb_block_ram_client.sv
// Directed bench for block_ram_client with a behavioural single-port RAM
// (1-cycle read latency, data out goes X after a write).
module tb_block_ram_client;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD = 3;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          REQ_VALID, REQ_READY, REQ_WE;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_DATA;
  logic          RESP_VALID, RESP_READY;
  logic [DW-1:0] RESP_DATA;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DI;
  logic          RAM_WE;
  logic [DW-1:0] RAM_DO;

  logic [DW-1:0] mem [16];

  int errors = 0;
  int checks = 0;

  block_ram_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(RD)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_WE(RAM_WE), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_WE) begin
      mem[RAM_ADDR] <= RAM_DI;
      RAM_DO        <= 'x;
    end else begin
      RAM_DO <= mem[RAM_ADDR];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before t=100000");
    $fatal(1);
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_DATA = d;
    while (REQ_READY !== 1'b1 && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    checks++;
    if (REQ_READY !== 1'b1) begin
      errors++; $display("FAIL write_accept_timeout: REQ_READY=%b required 1", REQ_READY);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
  endtask

  task automatic test_reset();
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = '0; REQ_DATA = 8'hFF; RESP_READY = 1'b0;
    #2;
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", REQ_READY); end
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", RESP_VALID); end
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b required 0", RAM_WE); end
    repeat (2) @(posedge CLK);
    #1;
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
    RESET_N = 1'b1;
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b required 0", REQ_READY); end
    @(posedge CLK); #1;
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL release_ready_edge: got %b required 1", REQ_READY); end
  endtask

  task automatic test_write_read();
    RESP_READY = 1'b1;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 4'd3; REQ_DATA = 8'hA5;
    #1;
    checks++; if (RAM_WE !== 1'b1) begin errors++; $display("FAIL wr_ram_we: got %b required 1", RAM_WE); end
    checks++; if (RAM_ADDR !== 4'd3 || RAM_DI !== 8'hA5) begin
      errors++; $display("FAIL wr_ram_bus: addr=%h di=%h required 3/a5", RAM_ADDR, RAM_DI); end
    @(posedge CLK); #1;
    REQ_WE = 1'b0;
    #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: RAM_WE=%b required 0", RAM_WE); end
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b required 1", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL rd_latency_early: RESP_VALID=%b required 0", RESP_VALID); end
    @(posedge CLK); #1;
    checks++; if (RESP_VALID !== 1'b1 || RESP_DATA !== 8'hA5) begin
      errors++; $display("FAIL rd_latency_data: valid=%b data=%h required 1/a5", RESP_VALID, RESP_DATA); end
    @(posedge CLK); #1;
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL rd_consumed: RESP_VALID=%b required 0", RESP_VALID); end
  endtask

  task automatic test_back_to_back();
    logic ev;
    for (int i = 0; i < 8; i++) do_write(4'(i), 8'(8'h10 + i));
    RESP_READY = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'(c);
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d: got %b required 1", c, REQ_READY); end
      end else begin
        REQ_VALID = 1'b0;
      end
      ev = (c >= 2 && c < 10);
      checks++; if (RESP_VALID !== ev) begin errors++; $display("FAIL b2b_valid c=%0d: got %b required %b", c, RESP_VALID, ev); end
      if (ev) begin
        checks++; if (RESP_DATA !== 8'(8'h10 + c - 2)) begin
          errors++; $display("FAIL b2b_data c=%0d: got %h required %h", c, RESP_DATA, 8'(8'h10 + c - 2)); end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_backpressure();
    logic er, ev;
    logic [DW-1:0] ed;
    for (int c = 0; c < 10; c++) begin
      RESP_READY = (c >= 6);
      REQ_VALID  = (c < 6); REQ_WE = 1'b0; REQ_ADDR = 4'(c);
      er = (c < 3) || (c >= 7);
      ev = (c >= 2) && (c < 9);
      ed = 8'(8'h10 + ((c >= 6) ? c - 6 : 0));
      checks++; if (REQ_READY !== er) begin errors++; $display("FAIL bp_ready c=%0d: got %b required %b", c, REQ_READY, er); end
      checks++; if (RESP_VALID !== ev) begin errors++; $display("FAIL bp_valid c=%0d: got %b required %b", c, RESP_VALID, ev); end
      if (ev) begin
        checks++; if (RESP_DATA !== ed) begin errors++; $display("FAIL bp_data c=%0d: got %h required %h", c, RESP_DATA, ed); end
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic test_alternate();
    logic ev;
    RESP_READY = 1'b1; REQ_ADDR = 4'd5; REQ_DATA = 8'h3C;
    for (int c = 0; c < 14; c++) begin
      REQ_VALID = (c < 12); REQ_WE = (c % 2 == 0);
      if (c < 12) begin
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL alt_ready c=%0d: got %b required 1", c, REQ_READY); end
      end
      ev = (c >= 3) && (c % 2 == 1);
      checks++; if (RESP_VALID !== ev) begin errors++; $display("FAIL alt_valid c=%0d: got %b required %b", c, RESP_VALID, ev); end
      if (ev) begin
        checks++; if (RESP_DATA !== 8'h3C) begin errors++; $display("FAIL alt_data c=%0d: got %h required 3c", c, RESP_DATA); end
      end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0; REQ_WE = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_write(4'd9, 8'h77);
    RESP_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'(c);
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rm_ready c=%0d: got %b required 1", c, REQ_READY); end
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
    checks++; if (REQ_READY !== 1'b0 || RESP_VALID !== 1'b1 || RESP_DATA !== 8'h10) begin
      errors++; $display("FAIL rm_full: ready=%b valid=%b data=%h required 0/1/10", REQ_READY, RESP_VALID, RESP_DATA); end
    #1 RESET_N = 1'b0;
    #1;
    checks++; if (RESP_VALID !== 1'b0 || REQ_READY !== 1'b0) begin
      errors++; $display("FAIL rm_async_drop: valid=%b ready=%b required 0/0", RESP_VALID, REQ_READY); end
    @(posedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if (REQ_READY !== 1'b1 || RESP_VALID !== 1'b0) begin
      errors++; $display("FAIL rm_after_release: ready=%b valid=%b required 1/0", REQ_READY, RESP_VALID); end
    RESP_READY = 1'b1; REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'd9;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL rm_no_stale: RESP_VALID=%b required 0", RESP_VALID); end
    @(posedge CLK); #1;
    checks++; if (RESP_VALID !== 1'b1 || RESP_DATA !== 8'h77) begin
      errors++; $display("FAIL rm_mem_intact: valid=%b data=%h required 1/77", RESP_VALID, RESP_DATA); end
    @(posedge CLK); #1;
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL rm_drained: RESP_VALID=%b required 0", RESP_VALID); end
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_m [16];
    logic [DW-1:0] q [$];
    logic infl = 1'b0;
    logic er, ev, fire;
    for (int i = 0; i < 16; i++) ref_m[i] = mem[i];
    for (int n = 0; n < 206; n++) begin
      er = (q.size() < RD);
      ev = (q.size() > int'(infl));
      checks++; if (REQ_READY !== er) begin errors++; $display("FAIL rnd_ready n=%0d: got %b required %b", n, REQ_READY, er); end
      checks++; if (RESP_VALID !== ev) begin errors++; $display("FAIL rnd_valid n=%0d: got %b required %b", n, RESP_VALID, ev); end
      if (ev) begin
        checks++; if (RESP_DATA !== q[0]) begin errors++; $display("FAIL rnd_data n=%0d: got %h required %h", n, RESP_DATA, q[0]); end
      end
      if (n < 200) begin
        RESP_READY = ($urandom_range(0, 3) != 0);
        REQ_VALID  = 1'($urandom_range(0, 1));
        REQ_WE     = ($urandom_range(0, 2) == 0);
        REQ_ADDR   = 4'($urandom_range(0, 15));
        REQ_DATA   = 8'($urandom_range(0, 255));
      end else begin
        RESP_READY = 1'b1; REQ_VALID = 1'b0;
      end
      fire = REQ_VALID && er;
      if (ev && RESP_READY) void'(q.pop_front());
      if (fire && REQ_WE) ref_m[REQ_ADDR] = REQ_DATA;
      if (fire && !REQ_WE) q.push_back(ref_m[REQ_ADDR]);
      infl = fire && !REQ_WE;
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_DATA = '0; RESP_READY = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
